// File: rtl/alarm_controller.sv
// Alarm controller: stores the alarm time, detects a match against the running clock
// and sequences the ringing/snooze behaviour with a beeping buzzer output.
module alarm_controller #(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_1hz_i,
    input  logic [5:0] sec_count_i,
    input  logic [5:0] min_count_i,
    input  logic [4:0] hour_count_i,
    input  logic       alarm_on_i,
    input  logic       set_min_i,
    input  logic       set_hour_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic [5:0] alarm_min_o,
    output logic [4:0] alarm_hour_o,
    output logic       armed_o,
    output logic       ringing_o,
    output logic       snoozing_o,
    output logic       buzzer_o
);

    localparam int unsigned RingW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int unsigned SnzW  = $clog2(SNOOZE_SEC + 1);

    localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT_SEC - 1);
    localparam logic [RingW-1:0] RingOne  = RingW'(1);
    localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SNOOZE_SEC);
    localparam logic [SnzW-1:0]  SnzOne   = SnzW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRinging,
        StSnooze
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       alarm_min_q, alarm_min_d;
    logic [4:0]       alarm_hour_q, alarm_hour_d;
    logic [RingW-1:0] ring_q, ring_d;
    logic [SnzW-1:0]  snz_q, snz_d;
    logic             buzzer_q, buzzer_d;
    logic             match, match_q, trigger;

    assign match   = (hour_count_i == alarm_hour_q) && (min_count_i == alarm_min_q) &&
                     (sec_count_i == 6'd0);
    // Fire only on the first cycle of a match window.
    assign trigger = match && !match_q;

    always_comb begin
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        if (state_q == StIdle || state_q == StArmed) begin
            if (set_min_i) begin
                alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
            end
            if (set_hour_i) begin
                alarm_hour_d = (alarm_hour_q == 5'd23) ? 5'd0 : alarm_hour_q + 5'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ring_d   = ring_q;
        snz_d    = snz_q;
        buzzer_d = buzzer_q;
        if (!alarm_on_i) begin
            state_d  = StIdle;
            ring_d   = '0;
            snz_d    = '0;
            buzzer_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (trigger) begin
                        state_d  = StRinging;
                        ring_d   = '0;
                        buzzer_d = 1'b1;
                    end
                end
                StRinging: begin
                    if (stop_i) begin
                        state_d = StArmed;
                    end else if (snooze_i) begin
                        state_d = StSnooze;
                        snz_d   = SnzLoad;
                    end else if (tick_1hz_i) begin
                        if (ring_q == RingLast) begin
                            state_d = StArmed;
                        end else begin
                            ring_d   = ring_q + RingOne;
                            buzzer_d = ~buzzer_q;
                        end
                    end
                end
                StSnooze: begin
                    if (stop_i) begin
                        state_d = StArmed;
                    end else if (tick_1hz_i) begin
                        if (snz_q == SnzOne) begin
                            state_d  = StRinging;
                            ring_d   = '0;
                            buzzer_d = 1'b1;
                            snz_d    = '0;
                        end else if (snz_q != '0) begin
                            snz_d = snz_q - SnzOne;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (state_d != StRinging) begin
            buzzer_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            alarm_min_q  <= 6'd0;
            alarm_hour_q <= 5'd0;
            ring_q       <= '0;
            snz_q        <= '0;
            buzzer_q     <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            ring_q       <= ring_d;
            snz_q        <= snz_d;
            buzzer_q     <= buzzer_d;
            match_q      <= match;
        end
    end

    assign alarm_min_o  = alarm_min_q;
    assign alarm_hour_o = alarm_hour_q;
    assign armed_o      = (state_q != StIdle);
    assign ringing_o    = (state_q == StRinging);
    assign snoozing_o   = (state_q == StSnooze);
    assign buzzer_o     = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed stimulus, a behavioural model compared every cycle,
// and literal expectations at key points.
module tb_alarm_controller;

    localparam int unsigned SNZ = 3;
    localparam int unsigned RT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] sec = 6'd0;
    logic [5:0] mn = 6'd0;
    logic [4:0] hour = 5'd0;
    logic       alarm_on = 1'b0;
    logic       set_min = 1'b0;
    logic       set_hour = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       armed, ringing, snoozing, buzzer;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_controller #(
        .SNOOZE_SEC       (SNZ),
        .RING_TIMEOUT_SEC (RT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_1hz_i   (tick),
        .sec_count_i  (sec),
        .min_count_i  (mn),
        .hour_count_i (hour),
        .alarm_on_i   (alarm_on),
        .set_min_i    (set_min),
        .set_hour_i   (set_hour),
        .snooze_i     (snooze),
        .stop_i       (stop),
        .alarm_min_o  (alarm_min),
        .alarm_hour_o (alarm_hour),
        .armed_o      (armed),
        .ringing_o    (ringing),
        .snoozing_o   (snoozing),
        .buzzer_o     (buzzer)
    );

    // Model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing. Ringing tracks ticks elapsed,
    // snooze tracks ticks left; the buzzer is high on even elapsed counts.
    int  m_mode = 0;
    int  m_am = 0;
    int  m_ah = 0;
    int  m_elapsed = 0;
    int  m_left = 0;
    bit  m_prev = 0;
    bit  m_valid = 0;

    always @(posedge clk) begin : model
        bit mt;
        bit trig;
        if (rst) begin
            m_mode = 0; m_am = 0; m_ah = 0; m_elapsed = 0; m_left = 0; m_prev = 0;
            m_valid = 1;
        end else if (m_valid) begin
            mt = (int'(hour) == m_ah) && (int'(mn) == m_am) && (sec == 6'd0);
            trig = mt && !m_prev;
            m_prev = mt;
            if (m_mode <= 1) begin
                if (set_min)  m_am = (m_am + 1) % 60;
                if (set_hour) m_ah = (m_ah + 1) % 24;
            end
            if (!alarm_on) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: m_mode = 1;
                    1: if (trig) begin m_mode = 2; m_elapsed = 0; end
                    2: begin
                        if (stop) m_mode = 1;
                        else if (snooze) begin m_mode = 3; m_left = SNZ; end
                        else if (tick) begin
                            m_elapsed++;
                            if (m_elapsed == RT) m_mode = 1;
                        end
                    end
                    default: begin
                        if (stop) m_mode = 1;
                        else if (tick) begin
                            m_left--;
                            if (m_left == 0) begin m_mode = 2; m_elapsed = 0; end
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [14:0] exp_v;
        logic [14:0] act_v;
        if (m_valid) begin
            exp_v = {6'(m_am), 5'(m_ah), m_mode != 0, m_mode == 2, m_mode == 3,
                     (m_mode == 2) && (m_elapsed % 2 == 0)};
            act_v = {alarm_min, alarm_hour, armed, ringing, snoozing, buzzer};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model t=%0t dut={min,hr,arm,ring,snz,buz}=%h model=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin set_min = 1'b1; cyc(1); set_min = 1'b0; cyc(1); end
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin set_hour = 1'b1; cyc(1); set_hour = 1'b0; cyc(1); end
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    endtask

    // Leave the match window for a cycle and re-enter it: a fresh trigger.
    task automatic retrigger();
        sec = 6'd1; cyc(1); sec = 6'd0; cyc(1);
    endtask

    initial begin
        cyc(2);
        chk("reset_min", alarm_min, 0);
        chk("reset_hour", alarm_hour, 0);
        chk("reset_armed", armed, 0);
        chk("reset_buzzer", buzzer, 0);
        rst = 1'b0;

        pulse_min(61);
        chk("min_wrap", alarm_min, 1);
        pulse_hour(25);
        chk("hour_wrap", alarm_hour, 1);
        chk("no_carry_min", alarm_min, 1);
        set_min = 1'b1; set_hour = 1'b1; cyc(1); set_min = 1'b0; set_hour = 1'b0; cyc(1);
        chk("both_min", alarm_min, 2);
        chk("both_hour", alarm_hour, 2);
        pulse_min(28);
        pulse_hour(5);
        chk("set_0730_min", alarm_min, 30);
        chk("set_0730_hour", alarm_hour, 7);

        hour = 5'd7; mn = 6'd29; sec = 6'd59; alarm_on = 1'b1; cyc(1);
        chk("armed_on", armed, 1);
        mn = 6'd30; sec = 6'd0; cyc(1);
        chk("ring_start", ringing, 1);
        chk("ring_buzz", buzzer, 1);
        for (int i = 1; i <= 4; i++) begin
            pulse_tick();
            if (i < 4) begin
                chk("ring_hold", ringing, 1);
                chk("buzz_toggle", buzzer, (i % 2 == 0) ? 1 : 0);
            end
        end
        chk("timeout_ring", ringing, 0);
        chk("timeout_armed", armed, 1);
        cyc(3);
        chk("no_retrigger_timeout", ringing, 0);

        retrigger();
        chk("ring2", ringing, 1);
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        chk("snoozing", snoozing, 1);
        chk("snooze_buzz", buzzer, 0);
        pulse_tick(); pulse_tick();
        chk("snooze_2ticks", snoozing, 1);
        pulse_tick();
        chk("rering", ringing, 1);
        chk("rering_buzz", buzzer, 1);

        pulse_min(1);
        chk("min_locked_ring", alarm_min, 30);
        stop = 1'b1; snooze = 1'b1; cyc(1); stop = 1'b0; snooze = 1'b0;
        chk("stopwin_armed", armed, 1);
        chk("stopwin_ring", ringing, 0);
        chk("stopwin_snz", snoozing, 0);
        cyc(3);
        chk("no_retrigger_stop", ringing, 0);

        retrigger();
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        chk("snz3", snoozing, 1);
        alarm_on = 1'b0; cyc(1);
        chk("off_armed", armed, 0);
        chk("off_snz", snoozing, 0);
        alarm_on = 1'b1; cyc(2);
        chk("rearm", armed, 1);
        chk("rearm_no_fire", ringing, 0);

        retrigger();
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("stop_snz_armed", armed, 1);
        chk("stop_snz", snoozing, 0);

        retrigger();
        chk("ring_pre_rst", ringing, 1);
        rst = 1'b1; cyc(1);
        chk("rst_ring", ringing, 0);
        chk("rst_buzz", buzzer, 0);
        chk("rst_min", alarm_min, 0);
        chk("rst_hour", alarm_hour, 0);
        chk("rst_armed", armed, 0);
        rst = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
